// File: rtl/countdown_timer_nbits.sv
// Loadable N-bit down-counter with a one-cycle done pulse when the count reaches zero.
// Optional periodic mode: define COUNTDOWN_AUTORELOAD_EN to reload from the last loaded value.
module countdown_timer_nbits #(
    parameter int N = 6
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [N-1:0] i_load_value,
    input  logic         i_start,
    input  logic         i_enable,
    output logic [N-1:0] o_count,
    output logic         o_busy,
    output logic         o_done,
    output logic [1:0]   o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [N-1:0] CNT_ZERO = '0;
    localparam logic [N-1:0] CNT_ONE  = N'(1);

    state_t       r_state;
    state_t       w_state_next;
    logic [N-1:0] r_count;
    logic [N-1:0] w_count_next;
    logic         r_done;
    logic         w_done_next;
    logic [N-1:0] w_reload_value;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [N-1:0] r_reload;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_reload <= '0;
        end else if (i_load) begin
            r_reload <= i_load_value;
        end
    end

    assign w_reload_value = r_reload;
`else
    // A zero reload value makes every terminal count behave as one-shot.
    assign w_reload_value = CNT_ZERO;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_done  <= w_done_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_done_next  = 1'b0;

        if (i_load) begin
            w_count_next = i_load_value;
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (r_count == CNT_ZERO) begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = RUN;
                        end
                    end
                end
                RUN, HOLD: begin
                    if (!i_enable) begin
                        w_state_next = HOLD;
                    end else if (r_count > CNT_ONE) begin
                        w_count_next = r_count - CNT_ONE;
                        w_state_next = RUN;
                    end else begin
                        // Terminal edge; a zero count here also ends the run rather than wrapping.
                        w_done_next = 1'b1;
                        if (w_reload_value != CNT_ZERO) begin
                            w_count_next = w_reload_value;
                            w_state_next = RUN;
                        end else begin
                            w_count_next = CNT_ZERO;
                            w_state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_busy  = (r_state == RUN) || (r_state == HOLD);
        o_state = r_state;
        o_count = r_count;
        o_done  = r_done;
    end

endmodule

// File: tb/tb_countdown_timer_nbits.sv
// Self-checking bench for countdown_timer_nbits against a behavioural model of the timer rules.
// Expectations follow COUNTDOWN_AUTORELOAD_EN when it is defined for the build.
module tb_countdown_timer_nbits;

    localparam int N = 6;
`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_load;
    logic [N-1:0] i_load_value;
    logic         i_start;
    logic         i_enable;
    logic [N-1:0] o_count;
    logic         o_busy;
    logic         o_done;
    logic [1:0]   o_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [N-1:0] m_count;
    logic [N-1:0] m_reload;
    logic [1:0]   m_state;
    logic         m_done;

    countdown_timer_nbits #(.N(N)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_load       (i_load),
        .i_load_value (i_load_value),
        .i_start      (i_start),
        .i_enable     (i_enable),
        .o_count      (o_count),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    function automatic logic [N+3:0] got();
        return {o_state, o_busy, o_done, o_count};
    endfunction

    function automatic logic [N+3:0] want();
        return {m_state, (m_state == ST_RUN) || (m_state == ST_HOLD), m_done, m_count};
    endfunction

    task automatic model_reset();
        m_count  = '0;
        m_reload = '0;
        m_state  = ST_IDLE;
        m_done   = 1'b0;
    endtask

    task automatic model_edge();
        if (i_load) begin
            m_count  = i_load_value;
            m_reload = i_load_value;
            m_state  = ST_IDLE;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_state)
                ST_IDLE: if (i_start) begin
                    if (m_count == 0) begin
                        m_state = ST_DONE;
                        m_done  = 1'b1;
                    end else begin
                        m_state = ST_RUN;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (!i_enable) begin
                        m_state = ST_HOLD;
                    end else if (m_count > 1) begin
                        m_count = m_count - 1;
                        m_state = ST_RUN;
                    end else begin
                        m_done = 1'b1;
                        if (AUTO && m_reload != 0) begin
                            m_count = m_reload;
                            m_state = ST_RUN;
                        end else begin
                            m_count = '0;
                            m_state = ST_DONE;
                        end
                    end
                end
                default: m_state = ST_IDLE;
            endcase
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (i_reset) model_edge();
        #1;
    endtask

    task automatic do_load(input logic [N-1:0] v);
        i_load = 1'b1;
        i_load_value = v;
        tick();
        i_load = 1'b0;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        int guard;
        i_reset = 1'b0;
        i_load = 1'b0;
        i_load_value = '0;
        i_start = 1'b0;
        i_enable = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (got() !== '0) begin
            n_fail++;
            $display("FAIL reset_init: got %h want %h", got(), '0);
        end
        #8 i_reset = 1'b1;
        tick();
        do_load(6'd20);
        i_enable = 1'b1;
        do_start();
        guard = 0;
        while (m_count != 12 && guard < 40) begin
            tick();
            guard++;
        end
        n_tests++;
        if (got() !== want() || o_count !== 6'd12) begin
            n_fail++;
            $display("FAIL reset_prerun: got %h want %h", got(), want());
        end
        #3 i_reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (got() !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", got(), '0);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (got() !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h want %h", got(), '0);
            end
        end
        #4 i_reset = 1'b1;
        i_enable = 1'b0;
        tick();
    endtask

    task automatic test_countdown();
        do_load(6'd5);
        i_enable = 1'b1;
        do_start();
        n_tests++;
        if (o_state !== ST_RUN || o_busy !== 1'b1 || o_count !== 6'd5 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL countdown_start: got %h want st=01 busy=1 done=0 cnt=5", got());
        end
        for (int k = 1; k <= 5; k++) begin
            logic [N-1:0] exp_cnt;
            tick();
            exp_cnt = (k == 5) ? (AUTO ? 6'd5 : 6'd0) : 6'(5 - k);
            n_tests++;
            if (o_count !== exp_cnt || o_done !== (k == 5) || got() !== want()) begin
                n_fail++;
                $display("FAIL countdown_step%0d: got %h want %h cnt=%0d", k, got(), want(), exp_cnt);
            end
        end
        if (!AUTO) begin
            n_tests++;
            if (o_state !== ST_DONE || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL countdown_done_state: got st=%b busy=%b want st=11 busy=0", o_state, o_busy);
            end
        end
        tick();
        n_tests++;
        if (o_done !== 1'b0 || got() !== want()) begin
            n_fail++;
            $display("FAIL countdown_after: got %h want %h", got(), want());
        end
        i_enable = 1'b0;
        do_load(6'd0);
    endtask

    task automatic test_pause();
        int enabled_edges;
        int guard;
        do_load(6'd63);
        i_enable = 1'b1;
        do_start();
        enabled_edges = 0;
        while (m_count != 60 && enabled_edges < 10) begin
            tick();
            enabled_edges++;
        end
        i_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (o_state !== ST_HOLD || o_count !== 6'd60 || o_busy !== 1'b1 || got() !== want()) begin
                n_fail++;
                $display("FAIL pause_hold%0d: got %h want st=10 cnt=60", k, got());
            end
        end
        i_enable = 1'b1;
        guard = 0;
        while (o_done !== 1'b1 && guard < 100) begin
            tick();
            enabled_edges++;
            guard++;
        end
        n_tests++;
        if (enabled_edges != 63 || got() !== want()) begin
            n_fail++;
            $display("FAIL pause_latency: got %0d enabled edges (%h) want 63 (%h)", enabled_edges, got(), want());
        end
        i_enable = 1'b0;
        do_load(6'd0);
    endtask

    task automatic test_zero_load();
        do_load(6'd0);
        i_enable = 1'b1;
        do_start();
        n_tests++;
        if (o_state !== ST_DONE || o_done !== 1'b1 || o_busy !== 1'b0 || got() !== want()) begin
            n_fail++;
            $display("FAIL zero_done: got %h want st=11 busy=0 done=1 cnt=0", got());
        end
        tick();
        n_tests++;
        if (got() !== '0 || got() !== want()) begin
            n_fail++;
            $display("FAIL zero_idle: got %h want %h", got(), '0);
        end
        i_enable = 1'b0;
    endtask

    task automatic test_load_priority();
        int guard;
        i_load = 1'b1;
        i_load_value = 6'd10;
        i_start = 1'b1;
        i_enable = 1'b1;
        tick();
        i_load = 1'b0;
        i_start = 1'b0;
        n_tests++;
        if (o_count !== 6'd10 || o_state !== ST_IDLE || got() !== want()) begin
            n_fail++;
            $display("FAIL loadstart_same: got %h want st=00 cnt=10", got());
        end
        do_start();
        guard = 0;
        while (m_count != 4 && guard < 20) begin
            tick();
            guard++;
        end
        do_load(6'd7);
        n_tests++;
        if (o_count !== 6'd7 || o_state !== ST_IDLE || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_abort: got %h want st=00 busy=0 done=0 cnt=7", got());
        end
        tick();
        n_tests++;
        if (o_done !== 1'b0 || got() !== want()) begin
            n_fail++;
            $display("FAIL load_abort_after: got %h want %h", got(), want());
        end
        i_enable = 1'b0;
    endtask

    task automatic test_reload();
        do_load(6'd3);
        i_enable = 1'b1;
        do_start();
        for (int k = 1; k <= 9; k++) begin
            logic [N-1:0] exp_cnt;
            logic         exp_done;
            tick();
            if (AUTO) begin
                exp_cnt  = 6'(3 - (k % 3));
                exp_done = (k % 3 == 0);
            end else begin
                exp_cnt  = (k <= 3) ? 6'(3 - k) : 6'd0;
                exp_done = (k == 3);
            end
            n_tests++;
            if (o_count !== exp_cnt || o_done !== exp_done || got() !== want()) begin
                n_fail++;
                $display("FAIL reload_step%0d: got %h want cnt=%0d done=%b (%h)", k, got(), exp_cnt, exp_done, want());
            end
        end
        do_load(6'd0);
        tick();
        n_tests++;
        if (got() !== '0 || got() !== want()) begin
            n_fail++;
            $display("FAIL reload_stop: got %h want %h", got(), '0);
        end
        i_enable = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            i_load       = ($urandom_range(0, 11) == 0);
            i_load_value = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 6)) : N'($urandom);
            i_start      = ($urandom_range(0, 2) == 0);
            i_enable     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #3 i_reset = 1'b0;
                model_reset();
                #1;
                n_tests++;
                if (got() !== want()) begin
                    n_fail++;
                    $display("FAIL random_reset%0d: got %h want %h", c, got(), want());
                end
                tick();
                #4 i_reset = 1'b1;
            end
            tick();
            n_tests++;
            if (got() !== want()) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %h want %h", c, got(), want());
            end
        end
        i_load = 1'b0;
        i_start = 1'b0;
        i_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_zero_load();
        test_load_priority();
        test_reload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer_nbits.md
Name: countdown_timer_nbits

Overview:
Loadable N-bit down-counter/timer; the counting-down counterpart of the team's N-bit up counter.
- Software/FSM logic loads a terminal value, starts it and can pause it with enable.
- The block decrements to zero, then emits a single-cycle done pulse.
- Used as a delay/timeout generator beside the up counter in lab datapaths.

Parameters:
N, 6, counter width in bits; load_value range 0..2^N-1

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears block immediately)
load  input  1  capture load_value into count on next edge; aborts any run
load_value  input  N  value to load
start  input  1  begin countdown from current count (honoured in IDLE only)
enable  input  1  count permission while running; 0 = pause
count  output  N  current counter value
busy  output  1  1 while state is RUN or HOLD
done  output  1  registered one-cycle pulse when count reaches 0
state  output  2  FSM state: IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Reset (reset=0, asynchronous): count=0, state=IDLE, busy=0, done=0, all immediately; holds while reset=0; first active edge after release evaluates normally.
- Priority per edge: reset > load > start > enable.
- load=1 in any state: count<=load_value, state<=IDLE, done<=0; a simultaneous start is ignored.
- IDLE, start=1, count!=0: state<=RUN; count unchanged on that edge; busy=1 from next cycle.
- IDLE, start=1, count==0: state<=DONE, done<=1 (zero-length run).
- RUN/HOLD, enable=1, count>1: count<=count-1, state<=RUN.
- RUN/HOLD, enable=1, count==1: count<=0, state<=DONE, done<=1.
- RUN/HOLD, enable=0: count held, state<=HOLD.
- DONE: lasts exactly one cycle, then state<=IDLE, done<=0; start in DONE is ignored.
- No underflow/wrap: count never decrements below 0.
- Latency: with load_value=L>0 and enable held high, done asserts on the L-th edge after the start edge (total L+1 edges from start sampled).
- busy = (state==RUN)||(state==HOLD), combinational from state.
- start or enable asserted in IDLE without start: no effect on count.
- Reset during RUN/HOLD aborts the run; no done pulse is produced.

Optional Feature:
COUNTDOWN_AUTORELOAD_EN
- Defined:
  - Adds an N-bit reload register, cleared by reset and written with load_value on every load.
  - In RUN/HOLD with enable=1 and count==1:
    - If reload!=0: count<=reload, state stays RUN, done<=1 for one cycle (periodic tick every reload enabled edges).
    - If reload==0: one-shot behaviour as above.
  - Only load or reset exits a periodic run.
- Not defined: strictly one-shot behaviour as above; no reload register is instantiated.

Test Plan:
1. Load 20, start, run to count 12, drive reset=0 between edges -> count=0, state=00, busy=0, done=0 immediately (before next edge); stays so until release.
2. N=6: load 5, start, enable=1 -> count 5,4,3,2,1,0 on successive edges; done=1 only on the cycle count becomes 0; state 01 then 11 then 00; busy drops when state becomes DONE.
3. Load 63, start, enable=1; at count 60 drive enable=0 for 3 edges -> state=10, count holds 60; resume -> done pulse after exactly 63 enabled edges total.
4. Load 0, start -> state 11 and done=1 after one edge, busy never asserts, then IDLE with count 0.
5. load=1 (value 10) and start=1 same edge -> count=10, state=IDLE, no decrement. Then start, and at count 4 load 7 -> count=7, state=IDLE, busy=0, no done pulse.
6. Load 3, start, enable=1:
   - With COUNTDOWN_AUTORELOAD_EN: count 3,2,1,3,2,1,... with done every 3rd edge; a later load of 0 ends the run.
   - Without it: 3,2,1,0, single done, then IDLE.
